// File: rtl/exp4_unidade_controle.sv
// Moore control unit sequencing the exp4_fluxo_dados memory-matching round.
// Optional espera timeout compiled in with `define UC_TIMEOUT_EN.
module exp4_unidade_controle #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  // state       | meaning
  // inicial     | idle, waiting for iniciar
  // preparacao  | clear address counter and switch register
  // espera      | waiting for the player's jogada
  // registra    | load switch register
  // comparacao  | check igual / fimC
  // proximo     | advance address counter
  // fim_acertou | round won
  // fim_errou   | round lost on mismatch
  // fim_timeout | round lost on timeout (feature build only)
  localparam logic [3:0] INICIAL     = 4'b0000;
  localparam logic [3:0] PREPARACAO  = 4'b0001;
  localparam logic [3:0] ESPERA      = 4'b0010;
  localparam logic [3:0] REGISTRA    = 4'b0100;
  localparam logic [3:0] COMPARACAO  = 4'b0101;
  localparam logic [3:0] PROXIMO     = 4'b0110;
  localparam logic [3:0] FIM_ACERTOU = 4'b1010;
  localparam logic [3:0] FIM_ERROU   = 4'b1110;
  localparam logic [3:0] FIM_TIMEOUT = 4'b1101;

  logic [3:0] state_q, state_d;
  logic       timeout_hit;

`ifdef UC_TIMEOUT_EN
  localparam logic [15:0] TMR_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmr_q, tmr_d;

  // Held at zero outside espera, so every entry restarts the count.
  assign tmr_d       = (state_q == ESPERA) ? tmr_q + 16'd1 : 16'd0;
  assign timeout_hit = (state_q == ESPERA) && (tmr_q == TMR_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) tmr_q <= 16'd0;
    else          tmr_q <= tmr_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg  = ^TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = INICIAL;
    case (state_q)
      INICIAL:     state_d = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:  state_d = ESPERA;
      ESPERA: begin
        if (jogada)           state_d = REGISTRA;
        else if (timeout_hit) state_d = FIM_TIMEOUT;
        else                  state_d = ESPERA;
      end
      REGISTRA:    state_d = COMPARACAO;
      COMPARACAO: begin
        if (!igual)    state_d = FIM_ERROU;
        else if (fimC) state_d = FIM_ACERTOU;
        else           state_d = PROXIMO;
      end
      PROXIMO:     state_d = ESPERA;
      FIM_ACERTOU: state_d = iniciar ? PREPARACAO : FIM_ACERTOU;
      FIM_ERROU:   state_d = iniciar ? PREPARACAO : FIM_ERROU;
`ifdef UC_TIMEOUT_EN
      FIM_TIMEOUT: state_d = iniciar ? PREPARACAO : FIM_TIMEOUT;
`endif
      default:     state_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= INICIAL;
    else          state_q <= state_d;
  end

  always_comb begin
    zeraC     = 1'b0;
    contaC    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    pronto    = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      PREPARACAO: begin
        zeraC = 1'b1;
        zeraR = 1'b1;
      end
      REGISTRA:   registraR = 1'b1;
      PROXIMO:    contaC    = 1'b1;
      FIM_ACERTOU: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      FIM_ERROU: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
`ifdef UC_TIMEOUT_EN
      FIM_TIMEOUT: begin
        pronto  = 1'b1;
        errou   = 1'b1;
        timeout = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign db_estado = state_q;

endmodule
